// File: rtl/run_monitor_if.sv
// Bundle for the run monitor: DUT run status in, run tracking results out.
interface run_monitor_if #(
    parameter int CNT_W  = 32,
    parameter int CODE_W = 32
);
    logic              retire_i;
    logic              halt_i;
    logic [CODE_W-1:0] exit_code_i;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  cycle_cnt_o;
    logic [CNT_W-1:0]  retire_cnt_o;
    logic [CODE_W-1:0] exit_code_o;
    logic              halted_o;
    logic              timeout_o;
    logic              stall_o;
    logic              finish_o;

    // Bench side: drives DUT status, observes results.
    modport master (
        output retire_i, halt_i, exit_code_i,
        input  state_o, cycle_cnt_o, retire_cnt_o, exit_code_o,
        input  halted_o, timeout_o, stall_o, finish_o
    );

    // Monitor side.
    modport slave (
        input  retire_i, halt_i, exit_code_i,
        output state_o, cycle_cnt_o, retire_cnt_o, exit_code_o,
        output halted_o, timeout_o, stall_o, finish_o
    );
endinterface

// File: rtl/run_monitor.sv
// Run monitor: follows a DUT run from reset release to termination and
// raises a one-cycle finish request with a sticky reason flag.
//
//   state | meaning
//   IDLE  | in/just out of reset, waiting one edge before the run starts
//   RUN   | program executing; timeout, stall and halt are checked
//   DRAIN | halt seen, letting the pipeline empty; only timeout can interrupt
//   DONE  | terminal until reset; counters frozen, one reason flag set
module run_monitor #(
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 100000,
    parameter int STALL_LIMIT  = 1000,
    parameter int DRAIN_CYCLES = 4,
    parameter int CODE_W       = 32
) (
    input logic          clk,
    input logic          rst,
    run_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // Terminal-count values; only used when the matching feature is enabled.
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STALL_LAST = CNT_W'(STALL_LIMIT - 1);
    localparam logic [DW-1:0]    C_DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
    localparam logic [DW-1:0]    C_DRAIN_ONE  = DW'(1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cycle_cnt, w_cycle_cnt_nxt;
    logic [CNT_W-1:0]   r_retire_cnt, w_retire_cnt_nxt;
    logic [CNT_W-1:0]   r_idle_cnt, w_idle_cnt_nxt;
    logic [DW-1:0]      r_drain_cnt, w_drain_cnt_nxt;
    logic [CODE_W-1:0]  r_exit_code, w_exit_code_nxt;
    logic               r_halted, w_halted_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic               r_stall, w_stall_nxt;
    logic               r_finish, w_finish_nxt;
    logic               w_timeout_hit;
    logic               w_stall_hit;
    logic [CNT_W-1:0]   w_retire_inc;

    assign w_retire_inc  = CNT_W'(mon.retire_i);
    assign w_timeout_hit = (TIMEOUT != 0) && (r_cycle_cnt == C_TO_LAST);
    assign w_stall_hit   = (STALL_LIMIT != 0) && !mon.retire_i
                           && (r_idle_cnt == C_STALL_LAST);

    // State register and all registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_idle_cnt   <= '0;
            r_drain_cnt  <= '0;
            r_exit_code  <= '0;
            r_halted     <= 1'b0;
            r_timeout    <= 1'b0;
            r_stall      <= 1'b0;
            r_finish     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cycle_cnt  <= w_cycle_cnt_nxt;
            r_retire_cnt <= w_retire_cnt_nxt;
            r_idle_cnt   <= w_idle_cnt_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_exit_code  <= w_exit_code_nxt;
            r_halted     <= w_halted_nxt;
            r_timeout    <= w_timeout_nxt;
            r_stall      <= w_stall_nxt;
            r_finish     <= w_finish_nxt;
        end
    end

    // Next-state and counter updates; termination priority is timeout > stall > halt.
    always_comb begin
        w_state_nxt      = r_state;
        w_cycle_cnt_nxt  = r_cycle_cnt;
        w_retire_cnt_nxt = r_retire_cnt;
        w_idle_cnt_nxt   = r_idle_cnt;
        w_drain_cnt_nxt  = r_drain_cnt;
        w_exit_code_nxt  = r_exit_code;
        w_halted_nxt     = r_halted;
        w_timeout_nxt    = r_timeout;
        w_stall_nxt      = r_stall;
        w_finish_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_cycle_cnt_nxt  = r_cycle_cnt + C_ONE;
                w_retire_cnt_nxt = r_retire_cnt + w_retire_inc;
                w_idle_cnt_nxt   = mon.retire_i ? '0 : (r_idle_cnt + C_ONE);
                if (w_timeout_hit) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_nxt = 1'b1;
                    w_finish_nxt  = 1'b1;
                end else if (w_stall_hit) begin
                    w_state_nxt  = ST_DONE;
                    w_stall_nxt  = 1'b1;
                    w_finish_nxt = 1'b1;
                end else if (mon.halt_i) begin
                    w_exit_code_nxt = mon.exit_code_i;
                    if (DRAIN_CYCLES == 0) begin
                        w_state_nxt  = ST_DONE;
                        w_halted_nxt = 1'b1;
                        w_finish_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = ST_DRAIN;
                        w_drain_cnt_nxt = C_DRAIN_INIT;
                    end
                end
            end
            ST_DRAIN: begin
                w_cycle_cnt_nxt  = r_cycle_cnt + C_ONE;
                w_retire_cnt_nxt = r_retire_cnt + w_retire_inc;
                if (w_timeout_hit) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_nxt = 1'b1;
                    w_finish_nxt  = 1'b1;
                end else if (r_drain_cnt == '0) begin
                    w_state_nxt  = ST_DONE;
                    w_halted_nxt = 1'b1;
                    w_finish_nxt = 1'b1;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - C_DRAIN_ONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mon.state_o      = r_state;
    assign mon.cycle_cnt_o  = r_cycle_cnt;
    assign mon.retire_cnt_o = r_retire_cnt;
    assign mon.exit_code_o  = r_exit_code;
    assign mon.halted_o     = r_halted;
    assign mon.timeout_o    = r_timeout;
    assign mon.stall_o      = r_stall;
    assign mon.finish_o     = r_finish;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: three instances with different limits share one
// stimulus stream; expected finish events are queued per instance and
// compared when each instance pulses finish_o.
module tb_run_monitor;

    logic clk;
    logic rst;
    int   edge_n;
    int   n_assert;
    int   n_fail;

    run_monitor_if #(.CNT_W(32), .CODE_W(32)) if_a ();
    run_monitor_if #(.CNT_W(32), .CODE_W(32)) if_b ();
    run_monitor_if #(.CNT_W(32), .CODE_W(32)) if_c ();

    run_monitor #(.CNT_W(32), .TIMEOUT(20), .STALL_LIMIT(8), .DRAIN_CYCLES(4), .CODE_W(32))
        u_a (.clk(clk), .rst(rst), .mon(if_a));
    run_monitor #(.CNT_W(32), .TIMEOUT(12), .STALL_LIMIT(0), .DRAIN_CYCLES(4), .CODE_W(32))
        u_b (.clk(clk), .rst(rst), .mon(if_b));
    run_monitor #(.CNT_W(32), .TIMEOUT(0), .STALL_LIMIT(0), .DRAIN_CYCLES(0), .CODE_W(32))
        u_c (.clk(clk), .rst(rst), .mon(if_c));

    typedef struct {
        int          edge_n;
        int          cyc;
        int          ret;
        logic [2:0]  flags;   // {halted, timeout, stall}
        bit          chk_code;
        logic [31:0] code;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // Stimulus configuration for drive_to.
    int          cur;
    int          ret_mode;   // 0 none, 1 every edge, 2 odd edges
    int          halt_e;
    int          halt_e2;
    logic [31:0] code1;
    logic [31:0] code2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index: 0 is the first posedge with rst low.
    always @(posedge clk) edge_n <= rst ? -1 : edge_n + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input int e, input int cyc, input int ret,
                        input logic [2:0] flags, input bit chk, input logic [31:0] code);
        exp_t x;
        x.edge_n = e; x.cyc = cyc; x.ret = ret; x.flags = flags;
        x.chk_code = chk; x.code = code;
        case (idx)
            0: q_a.push_back(x);
            1: q_b.push_back(x);
            default: q_c.push_back(x);
        endcase
    endtask

    task automatic mon_finish(input int idx, input string nm, input logic [1:0] st,
                              input logic [31:0] cyc, input logic [31:0] ret,
                              input logic [31:0] code, input logic h, input logic t,
                              input logic s);
        exp_t x;
        bit   have;
        have = 1'b0;
        case (idx)
            0: if (q_a.size() > 0) begin x = q_a.pop_front(); have = 1'b1; end
            1: if (q_b.size() > 0) begin x = q_b.pop_front(); have = 1'b1; end
            default: if (q_c.size() > 0) begin x = q_c.pop_front(); have = 1'b1; end
        endcase
        check({nm, "_finish_expected"}, 64'(have), 64'(1));
        if (have) begin
            check({nm, "_finish_edge"}, 64'(edge_n), 64'(x.edge_n));
            check({nm, "_finish_state"}, 64'(st), 64'(3));
            check({nm, "_cycle_cnt"}, 64'(cyc), 64'(x.cyc));
            check({nm, "_retire_cnt"}, 64'(ret), 64'(x.ret));
            check({nm, "_flags"}, 64'({h, t, s}), 64'(x.flags));
            if (x.chk_code) check({nm, "_exit_code"}, 64'(code), 64'(x.code));
        end
    endtask

    // Scoreboard consumer: one pop per finish pulse per instance.
    always @(negedge clk) begin
        if (if_a.finish_o === 1'b1)
            mon_finish(0, "A", if_a.state_o, if_a.cycle_cnt_o, if_a.retire_cnt_o,
                       if_a.exit_code_o, if_a.halted_o, if_a.timeout_o, if_a.stall_o);
        if (if_b.finish_o === 1'b1)
            mon_finish(1, "B", if_b.state_o, if_b.cycle_cnt_o, if_b.retire_cnt_o,
                       if_b.exit_code_o, if_b.halted_o, if_b.timeout_o, if_b.stall_o);
        if (if_c.finish_o === 1'b1)
            mon_finish(2, "C", if_c.state_o, if_c.cycle_cnt_o, if_c.retire_cnt_o,
                       if_c.exit_code_o, if_c.halted_o, if_c.timeout_o, if_c.stall_o);
    end

    task automatic set_in(input logic r, input logic h, input logic [31:0] c);
        if_a.retire_i = r; if_a.halt_i = h; if_a.exit_code_i = c;
        if_b.retire_i = r; if_b.halt_i = h; if_b.exit_code_i = c;
        if_c.retire_i = r; if_c.halt_i = h; if_c.exit_code_i = c;
    endtask

    // Drives edges cur+1 .. last; returns at the negedge after edge 'last'.
    task automatic drive_to(input int last);
        logic        r;
        logic        h;
        logic [31:0] c;
        for (int e = cur + 1; e <= last; e++) begin
            r = (ret_mode == 1) || ((ret_mode == 2) && ((e % 2) == 1));
            h = 1'b0;
            c = 32'h0;
            if (e == halt_e) begin h = 1'b1; c = code1; end
            else if (e == halt_e2) begin h = 1'b1; c = code2; end
            set_in(r, h, c);
            @(negedge clk);
        end
        cur = last;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        set_in(1'b1, 1'b1, 32'hFFFF_FFFF);
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        cur = -1;
    endtask

    task automatic check_cleared(input string nm, input logic [1:0] st,
                                 input logic [31:0] cyc, input logic [31:0] ret,
                                 input logic [31:0] code, input logic h, input logic t,
                                 input logic s, input logic f);
        check({nm, "_rst_state"}, 64'(st), 64'(0));
        check({nm, "_rst_cycle"}, 64'(cyc), 64'(0));
        check({nm, "_rst_retire"}, 64'(ret), 64'(0));
        check({nm, "_rst_code"}, 64'(code), 64'(0));
        check({nm, "_rst_flags"}, 64'({h, t, s, f}), 64'(0));
    endtask

    task automatic check_pending(input string nm);
        check({nm, "_pending_A"}, 64'(q_a.size()), 64'(0));
        check({nm, "_pending_B"}, 64'(q_b.size()), 64'(0));
        check({nm, "_pending_C"}, 64'(q_c.size()), 64'(0));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        ret_mode = 1;
        halt_e   = -1;
        halt_e2  = -1;
        code1    = 32'h0;
        code2    = 32'h0;
        cur      = -1;

        // Reset held with retire/halt asserted, then first run edge.
        rst = 1'b1;
        set_in(1'b1, 1'b1, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        check_cleared("t1_A", if_a.state_o, if_a.cycle_cnt_o, if_a.retire_cnt_o,
                      if_a.exit_code_o, if_a.halted_o, if_a.timeout_o, if_a.stall_o, if_a.finish_o);
        check_cleared("t1_C", if_c.state_o, if_c.cycle_cnt_o, if_c.retire_cnt_o,
                      if_c.exit_code_o, if_c.halted_o, if_c.timeout_o, if_c.stall_o, if_c.finish_o);
        rst = 1'b0;
        cur = -1;
        set_in(1'b1, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        cur = 0;
        check("t1_A_run_state", 64'(if_a.state_o), 64'(1));
        check("t1_A_run_cycle", 64'(if_a.cycle_cnt_o), 64'(0));
        check("t1_A_run_retire", 64'(if_a.retire_cnt_o), 64'(0));

        // Timeout with retire every edge.
        do_reset(2);
        ret_mode = 1; halt_e = -1; halt_e2 = -1;
        push(0, 20, 20, 20, 3'b010, 1'b1, 32'h0);
        push(1, 12, 12, 12, 3'b010, 1'b1, 32'h0);
        drive_to(21);
        check("t2_A_finish_one_cycle", 64'(if_a.finish_o), 64'(0));
        check("t2_A_done_hold", 64'(if_a.state_o), 64'(3));
        drive_to(25);
        check("t2_A_cycle_frozen", 64'(if_a.cycle_cnt_o), 64'(20));
        check("t2_A_retire_frozen", 64'(if_a.retire_cnt_o), 64'(20));
        check_pending("t2");

        // Stall: no retire from edge 0.
        do_reset(2);
        ret_mode = 0;
        push(0, 8, 8, 0, 3'b001, 1'b1, 32'h0);
        push(1, 12, 12, 0, 3'b010, 1'b1, 32'h0);
        drive_to(15);
        check_pending("t3");

        // Halt at 10 then a second halt at 11 that must not be captured.
        do_reset(2);
        ret_mode = 1; halt_e = 10; code1 = 32'h2A; halt_e2 = 11; code2 = 32'h55;
        push(0, 14, 14, 14, 3'b100, 1'b1, 32'h2A);
        push(1, 12, 12, 12, 3'b010, 1'b1, 32'h2A);
        push(2, 10, 10, 10, 3'b100, 1'b1, 32'h2A);
        drive_to(10);
        check("t4_A_drain_e10", 64'(if_a.state_o), 64'(2));
        drive_to(13);
        check("t4_A_drain_e13", 64'(if_a.state_o), 64'(2));
        drive_to(18);
        check_pending("t4");

        // Halt on the timeout edge; retire on odd edges only.
        do_reset(2);
        ret_mode = 2; halt_e = 12; code1 = 32'h77; halt_e2 = -1;
        push(0, 16, 16, 8, 3'b100, 1'b1, 32'h77);
        push(1, 12, 12, 6, 3'b010, 1'b0, 32'h0);
        push(2, 12, 12, 6, 3'b100, 1'b1, 32'h77);
        drive_to(20);
        check_pending("t5");

        // Reset mid-DRAIN (A) and in DONE (C), then a fresh run.
        do_reset(2);
        ret_mode = 1; halt_e = 3; code1 = 32'h11; halt_e2 = -1;
        push(2, 3, 3, 3, 3'b100, 1'b1, 32'h11);
        drive_to(4);
        check("t6_A_in_drain", 64'(if_a.state_o), 64'(2));
        check("t6_C_in_done", 64'(if_c.state_o), 64'(3));
        do_reset(1);
        check_cleared("t6_A", if_a.state_o, if_a.cycle_cnt_o, if_a.retire_cnt_o,
                      if_a.exit_code_o, if_a.halted_o, if_a.timeout_o, if_a.stall_o, if_a.finish_o);
        check_cleared("t6_C", if_c.state_o, if_c.cycle_cnt_o, if_c.retire_cnt_o,
                      if_c.exit_code_o, if_c.halted_o, if_c.timeout_o, if_c.stall_o, if_c.finish_o);
        halt_e = 6; code1 = 32'h22;
        push(0, 10, 10, 10, 3'b100, 1'b1, 32'h22);
        push(1, 10, 10, 10, 3'b100, 1'b1, 32'h22);
        push(2, 6, 6, 6, 3'b100, 1'b1, 32'h22);
        drive_to(5);
        check("t6_A_recount_cycle", 64'(if_a.cycle_cnt_o), 64'(5));
        check("t6_A_recount_retire", 64'(if_a.retire_cnt_o), 64'(5));
        drive_to(12);
        check_pending("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
